// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bo;

   // Requester side: issues operands, watches status and result.
   modport master (
      output start, a, b, bin,
      input  busy, done, d, bo
   );

   // Subtractor side.
   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bo
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor_if.slave   sub
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bo_q, bo_d;

   // Full-subtractor cell on the current LSBs.
   logic diff_bit;
   logic br_next;
   logic [WIDTH-1:0] res_shifted;

   // Single full-subtractor cell and the result shift-in value.
   always_comb begin
      diff_bit    = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
      br_next     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
      res_shifted = {diff_bit, res_q[WIDTH-1:1]};
   end

   // Next-state and datapath control for IDLE/RUN/DONE.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      d_d     = d_q;
      bo_d    = bo_q;
      unique case (state_q)
         S_IDLE: begin
            if (sub.start) begin
               a_sh_d  = sub.a;
               b_sh_d  = sub.b;
               br_d    = sub.bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            res_d  = res_shifted;
            cnt_d  = cnt_q + 1'b1;
            // Last bit: publish the result together with the final borrow.
            if (cnt_q == CNT_LAST) begin
               d_d     = res_shifted;
               bo_d    = br_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         d_q     <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         d_q     <= d_d;
         bo_q    <= bo_d;
      end
   end

   // Status and result come straight from registers.
   assign sub.busy = (state_q == S_RUN);
   assign sub.done = (state_q == S_DONE);
   assign sub.d    = d_q;
   assign sub.bo   = bo_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor with a timeline model.
module tb_serial_subtractor;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   serial_subtractor_if #(.WIDTH(W)) ifc ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .sub (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Reference: {borrow, difference} of a - b - bin as plain integer arithmetic.
   function automatic logic [W:0] ref_sub(input int av, input int bv, input int cv);
      int diff;
      diff = av - bv - cv;
      ref_sub[W]     = (diff < 0);
      ref_sub[W-1:0] = W'((diff + (1 << (W + 1))) % (1 << W));
   endfunction

   // Model: m_since counts edges since acceptance (-1 when idle).
   int         m_since = -1;
   logic [W:0] m_cap   = '0;
   logic [W-1:0] m_d   = '0;
   logic       m_bo    = 1'b0;
   int         m_dones = 0;
   int         dut_dones = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_since <= -1;
         m_d     <= '0;
         m_bo    <= 1'b0;
      end else if (m_since < 0) begin
         if (ifc.start) begin
            m_since <= 0;
            m_cap   <= ref_sub(int'(ifc.a), int'(ifc.b), int'(ifc.bin));
         end
      end else if (m_since == W) begin
         m_since <= -1;
      end else begin
         m_since <= m_since + 1;
         if (m_since + 1 == W) begin
            m_d     <= m_cap[W-1:0];
            m_bo    <= m_cap[W];
            m_dones <= m_dones + 1;
         end
      end
   end

   // Compare DUT outputs against the model every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", int'(ifc.busy), int'(m_since >= 0 && m_since < W));
         chk("done", int'(ifc.done), int'(m_since == W));
         chk("d",    int'(ifc.d),    int'(m_d));
         chk("bo",   int'(ifc.bo),   int'(m_bo));
         chk("busy_done_excl", int'(ifc.busy & ifc.done), 0);
         if (ifc.done) dut_dones++;
      end
   end

   // One request: pulse start, wait for done with a bound, check literal result.
   task automatic op(input int av, input int bv, input int cv,
                     input int exp_d, input int exp_bo, input string tag);
      int n, busy_n;
      @(negedge clk);
      ifc.start = 1'b1; ifc.a = W'(av); ifc.b = W'(bv); ifc.bin = cv[0];
      @(posedge clk);
      n = 0; busy_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         ifc.start = 1'b0;
         ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.bin = 1'($urandom);
         n++;
         if (ifc.done) break;
         if (ifc.busy) busy_n++;
      end
      chk({tag, "_latency"}, n, W + 1);
      chk({tag, "_busy_cycles"}, busy_n, W);
      chk({tag, "_d"}, int'(ifc.d), exp_d);
      chk({tag, "_bo"}, int'(ifc.bo), exp_bo);
   endtask

   task automatic hold_check(input int exp_d, input int exp_bo, input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_hold_d"}, int'(ifc.d), exp_d);
      chk({tag, "_hold_bo"}, int'(ifc.bo), exp_bo);
   endtask

   initial begin
      logic [W:0] r;
      int dn;
      ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin = 1'b0;
      #1;
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_done", int'(ifc.done), 0);
      chk("rst_d",    int'(ifc.d),    0);
      chk("rst_bo",   int'(ifc.bo),   0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Model pins.
      r = ref_sub(9, 3, 0);  chk("model_9_3", int'(r), 6);
      r = ref_sub(0, 0, 1);  chk("model_0_0_1", int'(r), 31);

      op(9, 3, 0, 6, 0, "t9_3");
      op(3, 9, 0, 10, 1, "t3_9");
      op(0, 0, 1, 15, 1, "t0_0_1");
      op(15, 15, 1, 15, 1, "t15_15_1");
      hold_check(15, 1, "t15_15_1");
      op(15, 0, 0, 15, 0, "t15_0");
      hold_check(15, 0, "t15_0");

      // start held high with changing operands: one done every W+2 edges.
      @(negedge clk);
      dn = 0;
      for (int k = 0; k < 6 * (W + 2); k++) begin
         ifc.start = 1'b1;
         ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.bin = 1'($urandom);
         @(negedge clk);
         if (ifc.done) dn++;
      end
      ifc.start = 1'b0;
      chk("b2b_done_count", dn, 6);
      repeat (W + 3) @(negedge clk);

      // Reset two edges into RUN aborts without a done pulse.
      @(negedge clk);
      ifc.start = 1'b1; ifc.a = W'(12); ifc.b = W'(5); ifc.bin = 1'b0;
      @(posedge clk);
      @(negedge clk); ifc.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(ifc.busy), 0);
      chk("abort_done", int'(ifc.done), 0);
      chk("abort_d",    int'(ifc.d),    0);
      chk("abort_bo",   int'(ifc.bo),   0);
      @(negedge clk); rst = 1'b0;
      op(12, 5, 0, 7, 0, "t12_5");

      // Reset during DONE clears the freshly published result.
      op(3, 9, 0, 10, 1, "pre_done_rst");
      #1 rst = 1'b1;
      #1;
      chk("done_rst_done", int'(ifc.done), 0);
      chk("done_rst_d", int'(ifc.d), 0);
      chk("done_rst_bo", int'(ifc.bo), 0);
      @(negedge clk); rst = 1'b0;

      // Exhaustive sweep.
      for (int av = 0; av < 16; av++)
         for (int bv = 0; bv < 16; bv++)
            for (int cv = 0; cv < 2; cv++) begin
               r = ref_sub(av, bv, cv);
               op(av, bv, cv, int'(r[W-1:0]), int'(r[W]), "sweep");
            end

      // Random traffic, including start pulses while busy.
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         ifc.start = ($urandom_range(0, 3) == 0);
         ifc.a = W'($urandom); ifc.b = W'($urandom); ifc.bin = 1'($urandom);
      end
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (W + 3) @(negedge clk);

      chk("done_pulse_total", dut_dones, m_dones);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
